// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register (JOF32).
//
// Holds the 10-bit program counter and drives it straight out as the
// instruction memory address. The word read back in the same cycle is
// captured into the IF/ID register that feeds decode. Taken branches and
// jumps reload the PC and replace the wrong-path IF/ID entry with a bubble.
//
// Optional feature: define FETCH_HALT_EN to stop fetching when a word with
// opcode HALT_OPCODE is loaded. Only redirect or reset restarts fetch.
// Without the macro, halted is tied 0 and HALT_OPCODE is fetched like any
// other instruction.
//
// Parameters:
//   NOP_WORD    - word loaded into IF/ID on reset, redirect and halt bubbles
//   HALT_OPCODE - imem_data[31:27] value that halts fetch (FETCH_HALT_EN)
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   stall        in   hazard hold: freezes PC and IF/ID
//   redirect     in   taken branch/jump from decode (overrides everything)
//   target_addr  in   10-bit absolute redirect target
//   imem_addr    out  instruction memory address (= PC, combinational)
//   imem_data    in   instruction memory read data (same-cycle)
//   instruction  out  IF/ID instruction register
//   id_pc_plus1  out  IF/ID copy of fetch PC+1
//   id_valid     out  IF/ID holds a real instruction
//   halted       out  fetch stopped on halt opcode

module fetch_stage #(
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [9:0]  target_addr,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [9:0]  id_pc_plus1,
  output logic        id_valid,
  output logic        halted
);

  logic [9:0]  pc;
  logic [9:0]  pc_inc;
  logic [9:0]  pc_next;
  logic [31:0] instr_next;
  logic [9:0]  pc_plus1_next;
  logic        valid_next;
  logic        halt_q;
  logic        halt_next;

  // 10-bit modulo increment: 1023 wraps to 0 silently.
  assign pc_inc    = pc + 10'd1;
  assign imem_addr = pc;

  always_comb begin
    pc_next       = pc;
    instr_next    = instruction;
    pc_plus1_next = id_pc_plus1;
    valid_next    = id_valid;
    halt_next     = halt_q;

    if (redirect) begin
      pc_next       = target_addr;
      instr_next    = NOP_WORD;
      pc_plus1_next = '0;
      valid_next    = 1'b0;
      halt_next     = 1'b0;
    end else if (stall) begin
      // hold everything
    end
`ifdef FETCH_HALT_EN
    else if (halt_q) begin
      instr_next    = NOP_WORD;
      pc_plus1_next = '0;
      valid_next    = 1'b0;
    end
`endif
    else begin
      pc_next       = pc_inc;
      instr_next    = imem_data;
      pc_plus1_next = pc_inc;
      valid_next    = 1'b1;
`ifdef FETCH_HALT_EN
      // The halt word itself is delivered to decode as valid; the PC has
      // already stepped past it, so it freezes at halt address + 1.
      halt_next     = (imem_data[31:27] == HALT_OPCODE);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      instruction <= NOP_WORD;
      id_pc_plus1 <= '0;
      id_valid    <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      pc          <= pc_next;
      instruction <= instr_next;
      id_pc_plus1 <= pc_plus1_next;
      id_valid    <= valid_next;
      halt_q      <= halt_next;
    end
  end

`ifdef FETCH_HALT_EN
  assign halted = halt_q;
`else
  logic unused_halt_cfg;
  assign unused_halt_cfg = ^HALT_OPCODE;
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hDEAD_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [9:0]  target_addr;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [9:0]  id_pc_plus1;
  logic        id_valid;
  logic        halted;

  logic [31:0] imem [1024];

  int n_checks;
  int n_fail;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [9:0]  target;
    logic [31:0] instr;
    logic [9:0]  ppl;
    logic        valid;
    logic [9:0]  addr;
    logic        halted;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  fetch_stage #(.NOP_WORD(NOP), .HALT_OPCODE(5'b11111)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .target_addr(target_addr),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .instruction(instruction),
    .id_pc_plus1(id_pc_plus1),
    .id_valid(id_valid),
    .halted(halted)
  );

  assign imem_data = imem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] d(input int unsigned i);
    return 32'h1000_0000 + i;
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [9:0] t,
                              input logic [31:0] ins, input logic [9:0] p,
                              input logic v, input logic [9:0] a, input logic h);
    vec_t x;
    x.stall = s; x.redirect = r; x.target = t;
    x.instr = ins; x.ppl = p; x.valid = v; x.addr = a; x.halted = h;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " instruction"}, instruction, NOP);
    check({tag, " id_pc_plus1"}, {22'd0, id_pc_plus1}, 32'd0);
    check({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, " halted"}, {31'd0, halted}, 32'd0);
    check({tag, " imem_addr"}, {22'd0, imem_addr}, 32'd0);
  endtask

  // Called just after a falling edge: drives, pushes the expectation,
  // takes one rising edge, compares, and returns at the next falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    stall       = v.stall;
    redirect    = v.redirect;
    target_addr = v.target;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, required one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " instruction"}, instruction, e.instr);
      check({tag, " id_pc_plus1"}, {22'd0, id_pc_plus1}, {22'd0, e.ppl});
      check({tag, " id_valid"}, {31'd0, id_valid}, {31'd0, e.valid});
      check({tag, " imem_addr"}, {22'd0, imem_addr}, {22'd0, e.addr});
      check({tag, " halted"}, {31'd0, halted}, {31'd0, e.halted});
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int unsigned i = 0; i < 1024; i++) imem[i] = d(i);

    // free run from reset: edge k loads imem[k-1]
    for (int unsigned k = 1; k <= 7; k++)
      vecs.push_back(mk(0, 0, 0, d(k - 1), 10'(k), 1, 10'(k), 0));
    // stall 3 cycles at pc=7, then release loads imem[7]
    for (int unsigned k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 0, d(6), 10'd7, 1, 10'd7, 0));
    vecs.push_back(mk(0, 0, 0, d(7), 10'd8, 1, 10'd8, 0));
    for (int unsigned k = 9; k <= 12; k++)
      vecs.push_back(mk(0, 0, 0, d(k - 1), 10'(k), 1, 10'(k), 0));
    // redirect to 200 at pc=12
    vecs.push_back(mk(0, 1, 10'd200, NOP, 10'd0, 0, 10'd200, 0));
    vecs.push_back(mk(0, 0, 0, d(200), 10'd201, 1, 10'd201, 0));
    vecs.push_back(mk(0, 0, 0, d(201), 10'd202, 1, 10'd202, 0));
    // reach pc=30 with a valid word in IF/ID, then redirect+stall to 50
    vecs.push_back(mk(0, 1, 10'd29, NOP, 10'd0, 0, 10'd29, 0));
    vecs.push_back(mk(0, 0, 0, d(29), 10'd30, 1, 10'd30, 0));
    vecs.push_back(mk(1, 1, 10'd50, NOP, 10'd0, 0, 10'd50, 0));
    vecs.push_back(mk(0, 0, 0, d(50), 10'd51, 1, 10'd51, 0));
    // stall directly after a bubble keeps the bubble
    vecs.push_back(mk(0, 1, 10'd600, NOP, 10'd0, 0, 10'd600, 0));
    vecs.push_back(mk(1, 0, 0, NOP, 10'd0, 0, 10'd600, 0));
    vecs.push_back(mk(0, 0, 0, d(600), 10'd601, 1, 10'd601, 0));
    // wrap through 1023
    vecs.push_back(mk(0, 1, 10'd1022, NOP, 10'd0, 0, 10'd1022, 0));
    vecs.push_back(mk(0, 0, 0, d(1022), 10'd1023, 1, 10'd1023, 0));
    vecs.push_back(mk(0, 0, 0, d(1023), 10'd0, 1, 10'd0, 0));
    vecs.push_back(mk(0, 0, 0, d(0), 10'd1, 1, 10'd1, 0));

    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    target_addr = '0;
    #12;
    check_reset("reset");

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // async reset asserted mid-cycle while a redirect is pending
    redirect = 1'b1;
    target_addr = 10'd300;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(0, 0, 0, d(0), 10'd1, 1, 10'd1, 0), "post_rst");
    run_vec(mk(0, 0, 0, d(1), 10'd2, 1, 10'd2, 0), "post_rst2");

`ifdef FETCH_HALT_EN
    imem[4] = 32'hF800_0000;
    run_vec(mk(0, 1, 10'd0, NOP, 10'd0, 0, 10'd0, 0), "h_redir");
    for (int unsigned k = 1; k <= 4; k++)
      run_vec(mk(0, 0, 0, d(k - 1), 10'(k), 1, 10'(k), 0), "h_run");
    run_vec(mk(0, 0, 0, 32'hF800_0000, 10'd5, 1, 10'd5, 1), "h_load");
    run_vec(mk(0, 0, 0, NOP, 10'd0, 0, 10'd5, 1), "h_bub1");
    run_vec(mk(0, 0, 0, NOP, 10'd0, 0, 10'd5, 1), "h_bub2");
    run_vec(mk(1, 0, 0, NOP, 10'd0, 0, 10'd5, 1), "h_stall");
    run_vec(mk(0, 1, 10'd0, NOP, 10'd0, 0, 10'd0, 0), "h_clear");
    for (int unsigned k = 1; k <= 4; k++)
      run_vec(mk(0, 0, 0, d(k - 1), 10'(k), 1, 10'(k), 0), "h_rerun");
    run_vec(mk(0, 0, 0, 32'hF800_0000, 10'd5, 1, 10'd5, 1), "h_load2");
    run_vec(mk(0, 0, 0, NOP, 10'd0, 0, 10'd5, 1), "h_bub3");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("h_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(0, 0, 0, d(0), 10'd1, 1, 10'd1, 0), "h_post_rst");
`endif

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
